// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Purpose  : Round-robin arbiter that shares one APB master (apb_top) among
//            NREQ requesters. It latches the winner's command, drives the
//            master's newd/wr/ain/din interface until the master reports
//            completion, then returns read data and status to the winner.
// Ports    : clk, rst            - clock (rising edge), sync active-high reset
//            req/req_wr          - per-requester request level and direction
//            req_addr/req_wdata  - packed per-requester address / write data
//            gnt/done            - one-hot grant, one-cycle completion pulse
//            rdata/err           - read data and error status (valid with done)
//            m_newd/m_wr/m_ain/m_din  - command interface to the master
//            m_done/m_rdata/m_slverr  - completion interface from the master
// Options  : APB_ARB_TIMEOUT_EN  - abort a transfer after TIMEOUT cycles in
//            BUSY, completing it with err=1 (rdata left unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               m_newd,
    output logic               m_wr,
    output logic [AW-1:0]      m_ain,
    output logic [DW-1:0]      m_din,
    input  logic               m_done,
    input  logic [DW-1:0]      m_rdata,
    input  logic               m_slverr
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY    = 2'd1;
    localparam logic [1:0] c_RELEASE = 2'd2;

    logic [1:0]         r_state, w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr,   w_ptr_nxt;
    logic [c_PTR_W-1:0] r_win,   w_win_nxt;
    logic [NREQ-1:0]    r_gnt,   w_gnt_nxt;
    logic [NREQ-1:0]    r_done,  w_done_nxt;
    logic [DW-1:0]      r_rdata, w_rdata_nxt;
    logic               r_err,   w_err_nxt;
    logic               r_newd,  w_newd_nxt;
    logic               r_wr,    w_wr_nxt;
    logic [AW-1:0]      r_ain,   w_ain_nxt;
    logic [DW-1:0]      r_din,   w_din_nxt;

    logic [c_PTR_W-1:0] w_pick;
    logic [c_PTR_W-1:0] w_win_inc;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
`endif

    // Round-robin pick: scan downward so the candidate closest to the pointer
    // (upward, with wrap) is the last one written and therefore wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % NREQ]) begin
                w_pick = c_PTR_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at NREQ.
    assign w_win_inc = (int'(r_win) == NREQ - 1) ? '0 : r_win + c_PTR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_newd_nxt  = r_newd;
        w_wr_nxt    = r_wr;
        w_ain_nxt   = r_ain;
        w_din_nxt   = r_din;
`ifdef APB_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            c_IDLE: begin
                if (|req) begin
                    w_win_nxt   = w_pick;
                    w_gnt_nxt   = NREQ'(1) << w_pick;
                    w_wr_nxt    = req_wr[w_pick];
                    w_ain_nxt   = req_addr[int'(w_pick) * AW +: AW];
                    w_din_nxt   = req_wdata[int'(w_pick) * DW +: DW];
                    w_newd_nxt  = 1'b1;
                    w_state_nxt = c_BUSY;
`ifdef APB_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            c_BUSY: begin
                // Requester inputs are deliberately not looked at here: the
                // latched command stays on the master until it completes.
                if (m_done) begin
                    if (!r_wr) begin
                        w_rdata_nxt = m_rdata;
                    end
                    w_err_nxt   = m_slverr;
                    w_done_nxt  = NREQ'(1) << r_win;
                    w_newd_nxt  = 1'b0;
                    w_ptr_nxt   = w_win_inc;
                    w_state_nxt = c_RELEASE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = NREQ'(1) << r_win;
                    w_newd_nxt  = 1'b0;
                    w_ptr_nxt   = w_win_inc;
                    w_state_nxt = c_RELEASE;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                end
`endif
            end
            c_RELEASE: begin
                // One newd-low cycle lets the master return to its IDLE before
                // any new command; requests are not sampled here.
                w_gnt_nxt   = '0;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_newd_nxt  = 1'b0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_newd  <= 1'b0;
            r_wr    <= 1'b0;
            r_ain   <= '0;
            r_din   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
            r_newd  <= w_newd_nxt;
            r_wr    <= w_wr_nxt;
            r_ain   <= w_ain_nxt;
            r_din   <= w_din_nxt;
`ifdef APB_ARB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign rdata  = r_rdata;
    assign err    = r_err;
    assign m_newd = r_newd;
    assign m_wr   = r_wr;
    assign m_ain  = r_ain;
    assign m_din  = r_din;

endmodule
`default_nettype wire
